ece429_decode: RTL and testbench

- MIPS decode stage. Sits directly downstream of the fetch stage.
- Takes the PC from fetch and the instruction word returned by instruction memory.
- Reads the 32x32 register file, decodes control signals and immediates, and presents them through a one-cycle ID/EX pipeline register.
- Owns the write-back port of the register file.
- Detects load-use hazards and stalls fetch through stall_out.

---
 rtl/ece429_defs.sv | 71 +++++++
 rtl/ece429_decode_if.sv | 40 ++++
 rtl/ece429_regfile.sv | 49 ++++
 rtl/ece429_decode.sv | 154 +++++++++++++++
 tb/tb_ece429_decode.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/ece429_defs.sv
// Shared MIPS decode definitions: opcode/funct encodings, register indices,
// pipeline record types and the fetch/decode reset PC.
package ece429_defs;

  localparam logic [31:0] RESET_PC = 32'h80020000;

  localparam logic [4:0] R_ZERO = 5'd0;
  localparam logic [4:0] R_SP   = 5'd29;
  localparam logic [4:0] R_RA   = 5'd31;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FUNCT_JR  = 6'h08;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_imm;
    logic illegal;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] jump_target;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dest_addr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    ctrl_t       ctrl;
  } idex_t;

  // Only these instructions consume rt as a source operand; elsewhere the
  // rt field is a destination or an encoding sub-field.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SB) || (op == OP_SH) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/ece429_decode_if.sv
// ID/EX bus between decode (master) and execute (slave), including the
// execute-side backpressure signal.
interface ece429_decode_if;
  logic        stall_in;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] rs_data_out;
  logic [31:0] rt_data_out;
  logic [31:0] imm_out;
  logic [31:0] jump_target_out;
  logic [4:0]  rs_addr_out;
  logic [4:0]  rt_addr_out;
  logic [4:0]  dest_addr_out;
  logic [5:0]  opcode_out;
  logic [5:0]  funct_out;
  logic [4:0]  shamt_out;
  logic        reg_write_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic        branch_out;
  logic        jump_out;
  logic        alu_imm_out;
  logic        illegal_out;

  modport master (
    input  stall_in,
    output valid_out, pc_out, rs_data_out, rt_data_out, imm_out, jump_target_out,
           rs_addr_out, rt_addr_out, dest_addr_out, opcode_out, funct_out, shamt_out,
           reg_write_out, mem_read_out, mem_write_out, branch_out, jump_out,
           alu_imm_out, illegal_out
  );

  modport slave (
    output stall_in,
    input  valid_out, pc_out, rs_data_out, rt_data_out, imm_out, jump_target_out,
           rs_addr_out, rt_addr_out, dest_addr_out, opcode_out, funct_out, shamt_out,
           reg_write_out, mem_read_out, mem_write_out, branch_out, jump_out,
           alu_imm_out, illegal_out
  );
endinterface

// File: rtl/ece429_regfile.sv
// 32x32 MIPS register file: two asynchronous read ports with write-first
// bypass, one synchronous write port, r0 hard-wired to zero.
module ece429_regfile
  import ece429_defs::*;
#(
  parameter logic [31:0] STACK_INIT = 32'h7FFFFFF0
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [4:0]  rs_addr_in,
  input  logic [4:0]  rt_addr_in,
  output logic [31:0] rs_data_out,
  output logic [31:0] rt_data_out,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_addr_in,
  input  logic [31:0] wb_data_in
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_active;

  assign wr_active = wb_en_in && (wb_addr_in != R_ZERO);

  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
    if (wr_active) regs_d[wb_addr_in] = wb_data_in;
  end

  always_ff @(posedge clk_in) begin
    // NOTE: this array must be reset (r29 has a defined start value), so it
    // maps to flops rather than a RAM macro, which could not be cleared in one cycle.
    if (reset_in) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      regs_q[R_SP] <= STACK_INIT;
    end else begin
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rs_data_out = regs_q[rs_addr_in];
    rt_data_out = regs_q[rt_addr_in];
    if (wr_active && (wb_addr_in == rs_addr_in)) rs_data_out = wb_data_in;
    if (wr_active && (wb_addr_in == rt_addr_in)) rt_data_out = wb_data_in;
  end

endmodule

// File: rtl/ece429_decode.sv
// MIPS decode stage: register read, control/immediate decode, load-use hazard
// detection and a single ID/EX pipeline register.
module ece429_decode #(
  parameter logic [31:0] STACK_INIT = 32'h7FFFFFF0,
  parameter logic [31:0] RESET_PC   = ece429_defs::RESET_PC
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] insn_in,
  input  logic        insn_valid_in,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_addr_in,
  input  logic [31:0] wb_data_in,
  output logic        stall_out,
  ece429_decode_if.master idex
);
  import ece429_defs::*;

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] rs_data, rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  dest;
  ctrl_t       ctrl;
  logic        hazard;
  idex_t       idex_d, idex_q;

  assign op    = insn_in[31:26];
  assign rs    = insn_in[25:21];
  assign rt    = insn_in[20:16];
  assign rd    = insn_in[15:11];
  assign imm16 = insn_in[15:0];

  ece429_regfile #(.STACK_INIT(STACK_INIT)) u_regfile (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .rs_addr_in  (rs),
    .rt_addr_in  (rt),
    .rs_data_out (rs_data),
    .rt_data_out (rt_data),
    .wb_en_in    (wb_en_in),
    .wb_addr_in  (wb_addr_in),
    .wb_data_in  (wb_data_in)
  );

  always_comb begin
    ctrl = '0;
    dest = R_ZERO;
    case (op)
      OP_RTYPE: begin
        dest = rd;
        if (insn_in[5:0] == FUNCT_JR) ctrl.jump = 1'b1;
        else                          ctrl.reg_write = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        dest = rt;
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_imm   = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_imm   = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dest = rt;
        ctrl.reg_write = 1'b1;
        ctrl.alu_imm   = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: ctrl.branch = 1'b1;
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        dest = R_RA;
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // A write to r0 is architecturally a no-op; suppress it so NOP is clean.
    if (dest == R_ZERO) ctrl.reg_write = 1'b0;
  end

  always_comb begin
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = {16'h0, imm16};
      OP_LUI:                   imm_ext = {imm16, 16'h0};
      default:                  imm_ext = {{16{imm16[15]}}, imm16};
    endcase
  end

  // Load result is not available until after MEM, so a dependent instruction
  // directly behind a load must wait one cycle.
  assign hazard = idex_q.valid && idex_q.ctrl.mem_read && (idex_q.dest_addr != R_ZERO) &&
                  insn_valid_in &&
                  ((rs == idex_q.dest_addr) || (reads_rt(op) && (rt == idex_q.dest_addr)));

  assign stall_out = idex.stall_in || hazard;

  always_comb begin
    idex_d = idex_q;
    if (!idex.stall_in) begin
      if (hazard || !insn_valid_in) begin
        idex_d    = '0;
        idex_d.pc = pc_in;
      end else begin
        idex_d.valid       = 1'b1;
        idex_d.pc          = pc_in;
        idex_d.rs_data     = rs_data;
        idex_d.rt_data     = rt_data;
        idex_d.imm         = imm_ext;
        idex_d.jump_target = ((pc_in + 32'd4) & 32'hF000_0000) | {4'h0, insn_in[25:0], 2'b00};
        idex_d.rs_addr     = rs;
        idex_d.rt_addr     = rt;
        idex_d.dest_addr   = dest;
        idex_d.opcode      = op;
        idex_d.funct       = insn_in[5:0];
        idex_d.shamt       = insn_in[10:6];
        idex_d.ctrl        = ctrl;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      idex_q    <= '0;
      idex_q.pc <= RESET_PC;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign idex.valid_out       = idex_q.valid;
  assign idex.pc_out          = idex_q.pc;
  assign idex.rs_data_out     = idex_q.rs_data;
  assign idex.rt_data_out     = idex_q.rt_data;
  assign idex.imm_out         = idex_q.imm;
  assign idex.jump_target_out = idex_q.jump_target;
  assign idex.rs_addr_out     = idex_q.rs_addr;
  assign idex.rt_addr_out     = idex_q.rt_addr;
  assign idex.dest_addr_out   = idex_q.dest_addr;
  assign idex.opcode_out      = idex_q.opcode;
  assign idex.funct_out       = idex_q.funct;
  assign idex.shamt_out       = idex_q.shamt;
  assign idex.reg_write_out   = idex_q.ctrl.reg_write;
  assign idex.mem_read_out    = idex_q.ctrl.mem_read;
  assign idex.mem_write_out   = idex_q.ctrl.mem_write;
  assign idex.branch_out      = idex_q.ctrl.branch;
  assign idex.jump_out        = idex_q.ctrl.jump;
  assign idex.alu_imm_out     = idex_q.ctrl.alu_imm;
  assign idex.illegal_out     = idex_q.ctrl.illegal;

endmodule

// File: tb/tb_ece429_decode.sv
// Directed-vector bench for the MIPS decode stage; every expected value is
// hand-computed from the instruction encodings below.
module tb_ece429_decode;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [31:0] pc_in;
  logic [31:0] insn_in;
  logic        insn_valid_in;
  logic        wb_en_in;
  logic [4:0]  wb_addr_in;
  logic [31:0] wb_data_in;
  logic        stall_out;
  int          checks = 0;
  int          errors = 0;

  ece429_decode_if idex();

  ece429_decode dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .pc_in         (pc_in),
    .insn_in       (insn_in),
    .insn_valid_in (insn_valid_in),
    .wb_en_in      (wb_en_in),
    .wb_addr_in    (wb_addr_in),
    .wb_data_in    (wb_data_in),
    .stall_out     (stall_out),
    .idex          (idex.master)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset_in = 1'b1; idex.stall_in = 1'b0; insn_valid_in = 1'b0;
    pc_in = 32'h0; insn_in = 32'h0; wb_en_in = 1'b0; wb_addr_in = 5'd0; wb_data_in = 32'h0;
    tick(); tick();
    reset_in = 1'b0;
    checks++; if (idex.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", idex.valid_out); end
    checks++; if (idex.pc_out !== 32'h80020000) begin errors++; $display("FAIL reset_pc: got %h want 80020000", idex.pc_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    checks++; if (idex.reg_write_out !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", idex.reg_write_out); end
  endtask

  task automatic test_read_after_reset();
    // addu $1,$0,$29
    pc_in = 32'h80020000; insn_in = 32'h001D0821; insn_valid_in = 1'b1;
    tick();
    checks++; if (idex.rs_data_out !== 32'h0) begin errors++; $display("FAIL r0_read: got %h want 00000000", idex.rs_data_out); end
    checks++; if (idex.rt_data_out !== 32'h7FFFFFF0) begin errors++; $display("FAIL sp_read: got %h want 7ffffff0", idex.rt_data_out); end
    checks++; if (idex.dest_addr_out !== 5'd1) begin errors++; $display("FAIL addu_dest: got %0d want 1", idex.dest_addr_out); end
    checks++; if (idex.reg_write_out !== 1'b1) begin errors++; $display("FAIL addu_regwrite: got %b want 1", idex.reg_write_out); end
    checks++; if (idex.valid_out !== 1'b1) begin errors++; $display("FAIL addu_valid: got %b want 1", idex.valid_out); end
  endtask

  task automatic test_wb_bypass();
    // addi $6,$5,-1 decoded in the same cycle r5 is written back
    pc_in = 32'h80020004; insn_in = 32'h20A6FFFF;
    wb_en_in = 1'b1; wb_addr_in = 5'd5; wb_data_in = 32'hDEADBEEF;
    tick();
    wb_en_in = 1'b0;
    checks++; if (idex.rs_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs: got %h want deadbeef", idex.rs_data_out); end
    checks++; if (idex.imm_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm: got %h want ffffffff", idex.imm_out); end
    checks++; if (idex.dest_addr_out !== 5'd6) begin errors++; $display("FAIL addi_dest: got %0d want 6", idex.dest_addr_out); end
    checks++; if (idex.alu_imm_out !== 1'b1) begin errors++; $display("FAIL addi_aluimm: got %b want 1", idex.alu_imm_out); end
    // addu $1,$5,$0 reads the stored value; r0 write in the same cycle is dropped
    insn_in = 32'h00A00821;
    wb_en_in = 1'b1; wb_addr_in = 5'd0; wb_data_in = 32'h0000FFFF;
    tick();
    wb_en_in = 1'b0;
    checks++; if (idex.rs_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL r5_stored: got %h want deadbeef", idex.rs_data_out); end
    checks++; if (idex.rt_data_out !== 32'h0) begin errors++; $display("FAIL r0_bypass: got %h want 00000000", idex.rt_data_out); end
    insn_in = 32'h00000821; // addu $1,$0,$0 after the ignored r0 write
    tick();
    checks++; if (idex.rs_data_out !== 32'h0) begin errors++; $display("FAIL r0_stays_zero: got %h want 00000000", idex.rs_data_out); end
  endtask

  task automatic test_imm();
    insn_in = 32'h34028000; // ori $2,$0,0x8000
    tick();
    checks++; if (idex.imm_out !== 32'h00008000) begin errors++; $display("FAIL ori_imm: got %h want 00008000", idex.imm_out); end
    insn_in = 32'h2802FFFF; // slti $2,$0,-1
    tick();
    checks++; if (idex.imm_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL slti_imm: got %h want ffffffff", idex.imm_out); end
    insn_in = 32'h3C021234; // lui $2,0x1234
    tick();
    checks++; if (idex.imm_out !== 32'h12340000) begin errors++; $display("FAIL lui_imm: got %h want 12340000", idex.imm_out); end
    checks++; if (idex.dest_addr_out !== 5'd2) begin errors++; $display("FAIL lui_dest: got %0d want 2", idex.dest_addr_out); end
  endtask

  task automatic test_load_use();
    insn_in = 32'h8C830000; // lw $3,0($4)
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL lw_no_stall: got %b want 0", stall_out); end
    tick();
    checks++; if (idex.mem_read_out !== 1'b1) begin errors++; $display("FAIL lw_memread: got %b want 1", idex.mem_read_out); end
    insn_in = 32'h00633820; // add $7,$3,$3
    #1;
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %b want 1", stall_out); end
    tick();
    checks++; if (idex.valid_out !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b want 0", idex.valid_out); end
    checks++; if (idex.reg_write_out !== 1'b0) begin errors++; $display("FAIL bubble_regwrite: got %b want 0", idex.reg_write_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL stall_one_cycle: got %b want 0", stall_out); end
    tick();
    checks++; if (idex.valid_out !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", idex.valid_out); end
    checks++; if (idex.dest_addr_out !== 5'd7) begin errors++; $display("FAIL add_dest: got %0d want 7", idex.dest_addr_out); end
  endtask

  task automatic test_stall_in();
    insn_in = 32'h20A6FFFF; // addi $6,$5,-1
    tick();
    idex.stall_in = 1'b1;
    insn_in = 32'h3C021234;
    wb_en_in = 1'b1; wb_addr_in = 5'd8; wb_data_in = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL stallin_out[%0d]: got %b want 1", i, stall_out); end
      tick();
      wb_en_in = 1'b0;
      checks++; if (idex.dest_addr_out !== 5'd6 || idex.imm_out !== 32'hFFFFFFFF || idex.valid_out !== 1'b1)
        begin errors++; $display("FAIL stallin_hold[%0d]: got dest %0d imm %h valid %b want 6 ffffffff 1", i, idex.dest_addr_out, idex.imm_out, idex.valid_out); end
    end
    idex.stall_in = 1'b0;
    insn_in = 32'h01004821; // addu $9,$8,$0
    tick();
    checks++; if (idex.rs_data_out !== 32'h12345678) begin errors++; $display("FAIL wb_during_stall: got %h want 12345678", idex.rs_data_out); end
    checks++; if (idex.dest_addr_out !== 5'd9) begin errors++; $display("FAIL addu9_dest: got %0d want 9", idex.dest_addr_out); end
  endtask

  task automatic test_jump_illegal();
    pc_in = 32'h80020010; insn_in = 32'h0C008000; // jal 0x0008000
    tick();
    checks++; if (idex.jump_target_out !== 32'h80020000) begin errors++; $display("FAIL jal_target: got %h want 80020000", idex.jump_target_out); end
    checks++; if (idex.dest_addr_out !== 5'd31) begin errors++; $display("FAIL jal_dest: got %0d want 31", idex.dest_addr_out); end
    checks++; if (idex.reg_write_out !== 1'b1 || idex.jump_out !== 1'b1) begin errors++; $display("FAIL jal_ctrl: got rw %b j %b want 1 1", idex.reg_write_out, idex.jump_out); end
    insn_in = 32'hFC000000; // opcode 0x3F
    tick();
    checks++; if (idex.illegal_out !== 1'b1 || idex.reg_write_out !== 1'b0 || idex.valid_out !== 1'b1)
      begin errors++; $display("FAIL illegal: got ill %b rw %b valid %b want 1 0 1", idex.illegal_out, idex.reg_write_out, idex.valid_out); end
    insn_in = 32'h00000000; // NOP
    tick();
    checks++; if (idex.reg_write_out !== 1'b0 || idex.valid_out !== 1'b1) begin errors++; $display("FAIL nop: got rw %b valid %b want 0 1", idex.reg_write_out, idex.valid_out); end
    insn_valid_in = 1'b0;
    tick();
    checks++; if (idex.valid_out !== 1'b0) begin errors++; $display("FAIL invalid_bubble: got %b want 0", idex.valid_out); end
  endtask

  task automatic test_reset_override();
    insn_valid_in = 1'b1; insn_in = 32'h20A6FFFF; idex.stall_in = 1'b1;
    wb_en_in = 1'b1; wb_addr_in = 5'd5; wb_data_in = 32'hCAFEF00D;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0; idex.stall_in = 1'b0; wb_en_in = 1'b0;
    checks++; if (idex.valid_out !== 1'b0 || idex.pc_out !== 32'h80020000)
      begin errors++; $display("FAIL reset_over_stall: got valid %b pc %h want 0 80020000", idex.valid_out, idex.pc_out); end
    insn_in = 32'h00A00821; // addu $1,$5,$0
    tick();
    checks++; if (idex.rs_data_out !== 32'h0) begin errors++; $display("FAIL reset_over_wb: got %h want 00000000", idex.rs_data_out); end
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_wb_bypass();
    test_imm();
    test_load_use();
    test_stall_in();
    test_jump_illegal();
    test_reset_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
